seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg7_pkg.sv | 49 ++++
 rtl/seg7_inv.sv | 41 ++++
 rtl/seg_capture.sv | 155 +++++++++++++++
 tb/tb_seg_capture.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Brief   : Seven-segment patterns, decoded codes and capture FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_R     = 7'b1001110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_0    = 4'h0;
  localparam logic [3:0] CODE_1    = 4'h1;
  localparam logic [3:0] CODE_2    = 4'h2;
  localparam logic [3:0] CODE_3    = 4'h3;
  localparam logic [3:0] CODE_4    = 4'h4;
  localparam logic [3:0] CODE_5    = 4'h5;
  localparam logic [3:0] CODE_6    = 4'h6;
  localparam logic [3:0] CODE_7    = 4'h7;
  localparam logic [3:0] CODE_8    = 4'h8;
  localparam logic [3:0] CODE_9    = 4'h9;
  localparam logic [3:0] CODE_A    = 4'hA;
  localparam logic [3:0] CODE_B    = 4'hB;
  localparam logic [3:0] CODE_R    = 4'hC;
  localparam logic [3:0] CODE_DASH = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_inv.sv
`default_nettype none
// ============================================================================
// Module  : seg7_inv
// Brief   : Combinational inverse seven-segment table (pattern -> code).
// Revision: 1.0 - initial release
// ============================================================================
module seg7_inv
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    code    = CODE_0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (seg)
      SEG_0:     code = CODE_0;
      SEG_1:     code = CODE_1;
      SEG_2:     code = CODE_2;
      SEG_3:     code = CODE_3;
      SEG_4:     code = CODE_4;
      SEG_5:     code = CODE_5;
      SEG_6:     code = CODE_6;
      SEG_7:     code = CODE_7;
      SEG_8:     code = CODE_8;
      SEG_9:     code = CODE_9;
      SEG_A:     code = CODE_A;
      SEG_B:     code = CODE_B;
      SEG_R:     code = CODE_R;
      SEG_DASH:  code = CODE_DASH;
      SEG_BLANK: blank = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_capture.sv
`default_nettype none
// ============================================================================
// Module  : seg_capture
// Brief   : Captures a multiplexed seven-segment display into decoded frames.
// Revision: 1.0 - initial release
// ============================================================================
module seg_capture
  import seg7_pkg::*;
#(
  parameter int N_DIG  = 4,
  parameter int SETTLE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           SEG,
  input  logic [N_DIG-1:0]     AN,
  output logic [4*N_DIG-1:0]   CODE,
  output logic [N_DIG-1:0]     BLANK,
  output logic [N_DIG-1:0]     INVALID,
  output logic                 FRAME_VALID,
  input  logic                 FRAME_READY,
  output logic                 OVERRUN
);

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_DIG-1:0] ONE_N       = N_DIG'(1);

  cap_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [N_DIG-1:0]     an_lat;
  logic [IDX_W-1:0]     dig_idx;
  logic [N_DIG-1:0]     seen;
  logic [4*N_DIG-1:0]   stg_code;
  logic [N_DIG-1:0]     stg_blank;
  logic [N_DIG-1:0]     stg_inv;

  logic [3:0]           dec_code;
  logic                 dec_blank;
  logic                 dec_inv;

  logic [N_DIG-1:0]     an_low;
  logic                 an_one;
  logic [IDX_W-1:0]     an_idx;
  logic [N_DIG-1:0]     seen_next;
  logic                 frame_done;
  logic [4*N_DIG-1:0]   stg_code_nx;
  logic [N_DIG-1:0]     stg_blank_nx;
  logic [N_DIG-1:0]     stg_inv_nx;

  seg7_inv u_inv (
    .seg     (SEG),
    .code    (dec_code),
    .blank   (dec_blank),
    .invalid (dec_inv)
  );

  // A legal select has exactly one active-low bit
  assign an_low = ~AN;
  assign an_one = (an_low != '0) && ((an_low & (an_low - ONE_N)) == '0);

  always_comb begin
    an_idx = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (an_low[i]) an_idx = IDX_W'(i);
    end
  end

  // Staging image including the digit being sampled this cycle
  always_comb begin
    stg_code_nx  = stg_code;
    stg_blank_nx = stg_blank;
    stg_inv_nx   = stg_inv;
    for (int i = 0; i < N_DIG; i++) begin
      if (dig_idx == IDX_W'(i)) begin
        stg_code_nx[4*i +: 4] = dec_code;
        stg_blank_nx[i]       = dec_blank;
        stg_inv_nx[i]         = dec_inv;
      end
    end
  end

  assign seen_next  = seen | ~an_lat;
  assign frame_done = (state == ST_SAMPLE) && (seen_next == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      an_lat      <= '1;
      dig_idx     <= '0;
      seen        <= '0;
      stg_code    <= '0;
      stg_blank   <= '0;
      stg_inv     <= '0;
      CODE        <= '0;
      BLANK       <= '1;
      INVALID     <= '0;
      FRAME_VALID <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      // Handshake; a simultaneous completion below re-asserts FRAME_VALID
      if (FRAME_VALID && FRAME_READY) begin
        FRAME_VALID <= 1'b0;
        OVERRUN     <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (an_one) begin
            an_lat  <= AN;
            dig_idx <= an_idx;
            cnt     <= '0;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (AN != an_lat) begin
            state <= ST_IDLE;
          end else if (cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          stg_code  <= stg_code_nx;
          stg_blank <= stg_blank_nx;
          stg_inv   <= stg_inv_nx;
          state     <= ST_HOLD;
          if (frame_done) begin
            seen <= '0;
            if (!FRAME_VALID || FRAME_READY) begin
              CODE        <= stg_code_nx;
              BLANK       <= stg_blank_nx;
              INVALID     <= stg_inv_nx;
              FRAME_VALID <= 1'b1;
            end else begin
              OVERRUN <= 1'b1;
            end
          end else begin
            seen <= seen_next;
          end
        end
        ST_HOLD: begin
          if (AN != an_lat) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_capture
// Brief   : Directed, table-driven self-checking bench for seg_capture.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_capture;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0011000, SA = 7'b0001000, SB = 7'b0000011,
                         SC = 7'b1001110, SF = 7'b0111111, SBL = 7'b1111111,
                         SX = 7'b1010101;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] code;
    logic       blank;
    logic       invalid;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  SEG = 7'h7F;
  logic [3:0]  AN = 4'hF;
  logic [15:0] CODE;
  logic [3:0]  BLANK;
  logic [3:0]  INVALID;
  logic        FRAME_VALID;
  logic        FRAME_READY = 1'b0;
  logic        OVERRUN;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [16];

  seg_capture #(.N_DIG(4), .SETTLE(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .SEG         (SEG),
    .AN          (AN),
    .CODE        (CODE),
    .BLANK       (BLANK),
    .INVALID     (INVALID),
    .FRAME_VALID (FRAME_VALID),
    .FRAME_READY (FRAME_READY),
    .OVERRUN     (OVERRUN)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic select(input int d, input logic [6:0] seg, input int n);
    logic [3:0] an_v;
    an_v    = 4'hF;
    an_v[d] = 1'b0;
    AN      = an_v;
    SEG     = seg;
    tick(n);
  endtask

  // segs = {digit3, digit2, digit1, digit0}
  task automatic scan(input logic [27:0] segs, input bit gap);
    for (int d = 0; d < 4; d++) begin
      if (gap) begin
        AN = 4'hF;
        tick(1);
      end
      select(d, segs[7*d +: 7], 12);
    end
  endtask

  task automatic ack();
    AN          = 4'hF;
    FRAME_READY = 1'b1;
    tick(1);
    FRAME_READY = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " CODE"},        32'(CODE),        32'h0);
    check({tag, " BLANK"},       32'(BLANK),       32'hF);
    check({tag, " INVALID"},     32'(INVALID),     32'h0);
    check({tag, " FRAME_VALID"}, 32'(FRAME_VALID), 32'h0);
    check({tag, " OVERRUN"},     32'(OVERRUN),     32'h0);
  endtask

  initial begin
    vecs[0]  = '{S0,  4'h0, 1'b0, 1'b0};
    vecs[1]  = '{S1,  4'h1, 1'b0, 1'b0};
    vecs[2]  = '{S2,  4'h2, 1'b0, 1'b0};
    vecs[3]  = '{S3,  4'h3, 1'b0, 1'b0};
    vecs[4]  = '{S4,  4'h4, 1'b0, 1'b0};
    vecs[5]  = '{S5,  4'h5, 1'b0, 1'b0};
    vecs[6]  = '{S6,  4'h6, 1'b0, 1'b0};
    vecs[7]  = '{S7,  4'h7, 1'b0, 1'b0};
    vecs[8]  = '{S8,  4'h8, 1'b0, 1'b0};
    vecs[9]  = '{S9,  4'h9, 1'b0, 1'b0};
    vecs[10] = '{SA,  4'hA, 1'b0, 1'b0};
    vecs[11] = '{SB,  4'hB, 1'b0, 1'b0};
    vecs[12] = '{SC,  4'hC, 1'b0, 1'b0};
    vecs[13] = '{SBL, 4'h0, 1'b1, 1'b0};
    vecs[14] = '{SF,  4'hF, 1'b0, 1'b0};
    vecs[15] = '{SX,  4'h0, 1'b0, 1'b1};

    // Reset state
    tick(3);
    check_reset_vals("reset");
    reset = 1'b0;
    tick(2);

    // Basic frame, last digit entered from idle: valid exactly 10 cycles later
    for (int d = 0; d < 3; d++) begin
      AN = 4'hF;
      tick(1);
      select(d, (d == 0) ? S1 : (d == 1) ? S2 : S3, 12);
    end
    AN = 4'hF;
    tick(1);
    select(3, S4, 9);
    check("latency early FRAME_VALID", 32'(FRAME_VALID), 32'h0);
    tick(1);
    check("latency FRAME_VALID", 32'(FRAME_VALID), 32'h1);
    tick(3);
    check("basic FRAME_VALID held", 32'(FRAME_VALID), 32'h1);
    check("basic CODE",    32'(CODE),    32'h4321);
    check("basic BLANK",   32'(BLANK),   32'h0);
    check("basic INVALID", 32'(INVALID), 32'h0);
    check("basic OVERRUN", 32'(OVERRUN), 32'h0);
    ack();
    check("basic ack FRAME_VALID", 32'(FRAME_VALID), 32'h0);

    // Full inverse table, four digits per frame, back-to-back scans
    for (int f = 0; f < 4; f++) begin
      scan({vecs[4*f+3].seg, vecs[4*f+2].seg, vecs[4*f+1].seg, vecs[4*f].seg}, 1'b0);
      check($sformatf("table f%0d FRAME_VALID", f), 32'(FRAME_VALID), 32'h1);
      for (int j = 0; j < 4; j++) begin
        check($sformatf("table v%0d code", 4*f+j),    32'(CODE[4*j +: 4]), 32'(vecs[4*f+j].code));
        check($sformatf("table v%0d blank", 4*f+j),   32'(BLANK[j]),       32'(vecs[4*f+j].blank));
        check($sformatf("table v%0d invalid", 4*f+j), 32'(INVALID[j]),     32'(vecs[4*f+j].invalid));
      end
      if (f == 3) begin
        check("blank/invalid BLANK",   32'(BLANK),   32'h2);
        check("blank/invalid INVALID", 32'(INVALID), 32'h8);
      end
      ack();
      check($sformatf("table f%0d ack", f), 32'(FRAME_VALID), 32'h0);
    end

    // Digit 2 select too short, then just under the settle time
    AN = 4'hF;
    tick(1);
    select(0, S5, 12);
    select(1, S6, 12);
    select(2, S7, 5);
    select(3, S8, 12);
    check("short settle no FRAME_VALID", 32'(FRAME_VALID), 32'h0);
    AN = 4'hF;
    tick(1);
    select(2, SA, 7);
    AN = 4'hF;
    tick(3);
    check("7-cycle settle no FRAME_VALID", 32'(FRAME_VALID), 32'h0);
    select(2, S9, 12);
    check("settled digit2 FRAME_VALID", 32'(FRAME_VALID), 32'h1);
    check("settled digit2 CODE", 32'(CODE), 32'h8965);
    ack();

    // Overrun: consumer stalls through two further scans
    scan({S4, S3, S2, S1}, 1'b1);
    check("overrun first FRAME_VALID", 32'(FRAME_VALID), 32'h1);
    check("overrun first OVERRUN",     32'(OVERRUN),     32'h0);
    scan({S8, S7, S6, S5}, 1'b1);
    scan({SC, SB, SA, S9}, 1'b1);
    check("overrun CODE retained", 32'(CODE),        32'h4321);
    check("overrun OVERRUN set",   32'(OVERRUN),     32'h1);
    check("overrun FRAME_VALID",   32'(FRAME_VALID), 32'h1);
    ack();
    check("overrun ack FRAME_VALID", 32'(FRAME_VALID), 32'h0);
    check("overrun ack OVERRUN",     32'(OVERRUN),     32'h0);

    // Illegal selects are never sampled and leave seen bits alone
    scan({S4, S3, S2, S1}, 1'b1);
    ack();
    for (int d = 0; d < 3; d++) begin
      AN = 4'hF;
      tick(1);
      select(d, (d == 0) ? S1 : (d == 1) ? S2 : S3, 12);
    end
    AN  = 4'b0011;
    SEG = S8;
    tick(20);
    check("multi-low no FRAME_VALID", 32'(FRAME_VALID), 32'h0);
    AN = 4'b1111;
    tick(20);
    check("no-low no FRAME_VALID", 32'(FRAME_VALID), 32'h0);
    select(3, S4, 12);
    check("after illegal FRAME_VALID", 32'(FRAME_VALID), 32'h1);
    check("after illegal CODE",        32'(CODE),        32'h4321);
    ack();

    // Reset mid-frame discards partial staging
    for (int d = 0; d < 3; d++) begin
      AN = 4'hF;
      tick(1);
      select(d, (d == 0) ? S7 : (d == 1) ? S8 : S9, 12);
    end
    AN = 4'hF;
    tick(1);
    #2;
    reset = 1'b1;
    #3;
    check_reset_vals("mid-frame reset");
    tick(2);
    reset = 1'b0;
    tick(1);
    select(3, S5, 12);
    AN = 4'hF;
    tick(5);
    check("post-reset lone digit no FRAME_VALID", 32'(FRAME_VALID), 32'h0);
    scan({S4, S3, S2, S1}, 1'b1);
    check("post-reset FRAME_VALID", 32'(FRAME_VALID), 32'h1);
    check("post-reset CODE",        32'(CODE),        32'h5321);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
